// File: rtl/time_set_ctrl_if.sv
// Button, time-register and write-bus bundle for time_set_ctrl.
// The master modport is the surrounding system; the slave modport is the controller.
interface time_set_ctrl_if;
    logic       edit_req;
    logic       btn_next;
    logic       btn_up;
    logic       btn_down;
    logic       btn_ok;
    logic [7:0] hour_in;
    logic [7:0] min_in;
    logic [7:0] sec_in;
    logic [7:0] dato_out;
    logic       en_sec;
    logic       en_min;
    logic       en_hour;
    logic [1:0] field_sel;
    logic [7:0] edit_hour;
    logic [7:0] edit_min;
    logic [7:0] edit_sec;
    logic       editing;
    logic       done;

    modport master (
        output edit_req, btn_next, btn_up, btn_down, btn_ok,
        output hour_in, min_in, sec_in,
        input  dato_out, en_sec, en_min, en_hour, field_sel,
        input  edit_hour, edit_min, edit_sec, editing, done
    );

    modport slave (
        input  edit_req, btn_next, btn_up, btn_down, btn_ok,
        input  hour_in, min_in, sec_in,
        output dato_out, en_sec, en_min, en_hour, field_sel,
        output edit_hour, edit_min, edit_sec, editing, done
    );
endinterface

// File: rtl/time_set_ctrl.sv
// Time-setting sequencer: snapshot, edit with wrap-around, then write sec/min/hour on a shared bus.
// Optional feature macro TIME_SET_TIMEOUT_EN adds an idle timeout in EDIT (TIMEOUT_CYC cycles).
module time_set_ctrl #(
    parameter int unsigned HOUR_MAX    = 23,
    parameter int unsigned MINSEC_MAX  = 59
`ifdef TIME_SET_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYC = 50000000
`endif
) (
    input  logic          clk,
    input  logic          reset,
    time_set_ctrl_if.slave bus
);
    localparam logic [7:0] HMAX  = 8'(HOUR_MAX);
    localparam logic [7:0] MSMAX = 8'(MINSEC_MAX);

    typedef enum logic [2:0] {IDLE, LOAD, EDIT, WR_SEC, WR_MIN, WR_HOUR, DONE} state_t;

    state_t state;

`ifdef TIME_SET_TIMEOUT_EN
    logic [31:0] idle_cnt;
`endif

    function automatic logic [7:0] step(input logic [7:0] val, input logic [7:0] max,
                                        input logic up);
        if (up)
            return (val == max) ? 8'd0 : val + 8'd1;
        else
            return (val == 8'd0) ? max : val - 8'd1;
    endfunction

    function automatic logic [7:0] clamp(input logic [7:0] val, input logic [7:0] max);
        return (val > max) ? 8'd0 : val;
    endfunction

    // Outputs are registered alongside the state so each reflects the state it belongs to.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            bus.dato_out  <= '0;
            bus.en_sec    <= 1'b0;
            bus.en_min    <= 1'b0;
            bus.en_hour   <= 1'b0;
            bus.field_sel <= 2'd0;
            bus.edit_hour <= '0;
            bus.edit_min  <= '0;
            bus.edit_sec  <= '0;
            bus.editing   <= 1'b0;
            bus.done      <= 1'b0;
`ifdef TIME_SET_TIMEOUT_EN
            idle_cnt      <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    bus.done <= 1'b0;
                    if (bus.edit_req) begin
                        state       <= LOAD;
                        bus.editing <= 1'b1;
                    end
                end
                LOAD: begin
                    bus.edit_hour <= clamp(bus.hour_in, HMAX);
                    bus.edit_min  <= clamp(bus.min_in, MSMAX);
                    bus.edit_sec  <= clamp(bus.sec_in, MSMAX);
                    bus.field_sel <= 2'd0;
                    state         <= EDIT;
`ifdef TIME_SET_TIMEOUT_EN
                    idle_cnt      <= '0;
`endif
                end
                EDIT: begin
`ifdef TIME_SET_TIMEOUT_EN
                    idle_cnt <= '0;
`endif
                    // One event per cycle; up and down together is an event that changes nothing.
                    if (bus.btn_ok) begin
                        state        <= WR_SEC;
                        bus.editing  <= 1'b0;
                        bus.en_sec   <= 1'b1;
                        bus.dato_out <= bus.edit_sec;
                    end else if (bus.btn_next) begin
                        bus.field_sel <= (bus.field_sel == 2'd2) ? 2'd0 : bus.field_sel + 2'd1;
                    end else if (bus.btn_up || bus.btn_down) begin
                        if (bus.btn_up ^ bus.btn_down) begin
                            case (bus.field_sel)
                                2'd0:    bus.edit_sec  <= step(bus.edit_sec, MSMAX, bus.btn_up);
                                2'd1:    bus.edit_min  <= step(bus.edit_min, MSMAX, bus.btn_up);
                                default: bus.edit_hour <= step(bus.edit_hour, HMAX, bus.btn_up);
                            endcase
                        end
                    end
`ifdef TIME_SET_TIMEOUT_EN
                    else if (idle_cnt == 32'(TIMEOUT_CYC - 1)) begin
                        state       <= IDLE;
                        bus.editing <= 1'b0;
                    end else begin
                        idle_cnt <= idle_cnt + 32'd1;
                    end
`endif
                end
                WR_SEC: begin
                    bus.en_sec   <= 1'b0;
                    bus.en_min   <= 1'b1;
                    bus.dato_out <= bus.edit_min;
                    state        <= WR_MIN;
                end
                WR_MIN: begin
                    bus.en_min   <= 1'b0;
                    bus.en_hour  <= 1'b1;
                    bus.dato_out <= bus.edit_hour;
                    state        <= WR_HOUR;
                end
                WR_HOUR: begin
                    bus.en_hour  <= 1'b0;
                    bus.dato_out <= '0;
                    bus.done     <= 1'b1;
                    state        <= DONE;
                end
                DONE: begin
                    bus.done <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
